// File: rtl/load_store_unit.sv
// Load/store initiator for a word-only Data_Memory: lane extraction with sign/zero
// extension on loads, read-modify-write for byte and halfword stores, one request in flight.
module load_store_unit #(
    parameter int ADDR_WIDTH  = 32,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Req_Valid,
    output logic                  Req_Ready,
    input  logic                  Req_Write,
    input  logic [1:0]            Req_Size,
    input  logic                  Req_Unsigned,
    input  logic [ADDR_WIDTH-1:0] Req_Address,
    input  logic [31:0]           Req_Write_Data,
    output logic                  Resp_Valid,
    output logic [31:0]           Resp_Read_Data,
    output logic                  Misaligned,
    output logic                  Memory_Write,
    output logic [ADDR_WIDTH-1:0] ALU_Result,
    output logic [31:0]           Memory_Write_Data,
    input  logic [31:0]           Read_Data
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t                  state;
    state_t                  stateNext;
    logic                    errFlag;
    logic                    reqWrite;
    logic [1:0]              reqSize;
    logic                    reqUnsigned;
    logic [ADDR_WIDTH-1:0]   reqAddr;
    logic [31:0]             reqWData;
    logic [31:0]             rdWord;
    logic                    accept;
    logic                    misalignReq;
    logic [ADDR_WIDTH-1:0]   alignedAddr;

    function automatic logic [31:0] laneLoad(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] offs, input logic uns);
        logic signed [7:0]  byteLane;
        logic signed [15:0] halfLane;
        logic [31:0]        result;
        byteLane = word[{offs, 3'b000} +: 8];
        halfLane = word[{offs[1], 4'b0000} +: 16];
        if (size[1])
            result = word;
        else if (size[0])
            result = uns ? {16'h0000, halfLane} : {{16{halfLane[15]}}, halfLane};
        else
            result = uns ? {24'h000000, byteLane} : {{24{byteLane[7]}}, byteLane};
        return result;
    endfunction

    function automatic logic [31:0] laneMerge(input logic [31:0] word, input logic [15:0] data,
                                              input logic half, input logic [1:0] offs);
        logic [31:0] result;
        result = word;
        if (half)
            result[{offs[1], 4'b0000} +: 16] = data;
        else
            result[{offs, 3'b000} +: 8] = data[7:0];
        return result;
    endfunction

    assign accept      = Req_Valid && Req_Ready;
    assign alignedAddr = {reqAddr[ADDR_WIDTH-1:2], 2'b00};
    assign misalignReq = ALIGN_CHECK &&
                         (((Req_Size == 2'b01) && Req_Address[0]) ||
                          (Req_Size[1] && (Req_Address[1:0] != 2'b00)));

    // Control: state, error decision and the held response word
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state          <= IDLE;
            errFlag        <= 1'b0;
            Resp_Read_Data <= '0;
        end else begin
            state <= stateNext;
            if (accept)
                errFlag <= misalignReq;
            if (stateNext == RESP)
                Resp_Read_Data <= (state == READ && !reqWrite) ?
                                  laneLoad(Read_Data, reqSize, reqAddr[1:0], reqUnsigned) : '0;
        end
    end

    // Request fields latched at accept; later Req_* activity is ignored
    always_ff @(posedge Clk) begin
        if (accept) begin
            reqWrite    <= Req_Write;
            reqSize     <= Req_Size;
            reqUnsigned <= Req_Unsigned;
            reqAddr     <= Req_Address;
            reqWData    <= Req_Write_Data;
        end
        if (state == READ)
            rdWord <= Read_Data;
    end

    // Memory-side outputs decode from state so reset removes the write strobe immediately
    always_comb begin
        stateNext         = state;
        Req_Ready         = 1'b0;
        Resp_Valid        = 1'b0;
        Misaligned        = 1'b0;
        Memory_Write      = 1'b0;
        ALU_Result        = '0;
        Memory_Write_Data = '0;
        case (state)
            IDLE: begin
                Req_Ready = 1'b1;
                if (Req_Valid) begin
                    if (misalignReq)
                        stateNext = RESP;
                    else if (Req_Write && Req_Size[1])
                        stateNext = WRITE;
                    else
                        stateNext = READ;
                end
            end
            READ: begin
                ALU_Result = alignedAddr;
                stateNext  = reqWrite ? WRITE : RESP;
            end
            WRITE: begin
                ALU_Result        = alignedAddr;
                Memory_Write      = 1'b1;
                Memory_Write_Data = reqSize[1] ? reqWData :
                                    laneMerge(rdWord, reqWData[15:0], reqSize[0], reqAddr[1:0]);
                stateNext         = RESP;
            end
            RESP: begin
                Resp_Valid = 1'b1;
                Misaligned = errFlag;
                stateNext  = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule
